// File: rtl/decimal_entry_pkg.sv
// Shared types for the decimal keypad entry unit: register-file write payload,
// BCD digits, entry FSM states and small arithmetic helpers.
package decimal_entry_pkg;

    localparam int unsigned REG_ID_W       = 5;
    localparam int unsigned OP_W           = 32;
    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned ACC_W          = 14;
    localparam int unsigned PREVIEW_DIGITS = 4;
    localparam int unsigned PREVIEW_EN_W   = 8;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [OP_W-1:0]     op_t;
    typedef logic [DIGIT_W-1:0]  digit_t;
    typedef logic [ACC_W-1:0]    acc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_WRITE = 2'd2
    } entry_state_t;

    // value*10 + digit as (value<<3) + (value<<1) + digit
    function automatic acc_t times10_plus(input acc_t value, input digit_t digit);
        return acc_t'(value << 3) + acc_t'(value << 1) + ACC_W'(digit);
    endfunction

    // Display enable mask; one digit stays lit even with nothing entered
    function automatic logic [PREVIEW_EN_W-1:0] enable_mask(input int unsigned count);
        logic [PREVIEW_EN_W-1:0] mask;
        case (count)
            0, 1:    mask = 8'h01;
            2:       mask = 8'h03;
            3:       mask = 8'h07;
            default: mask = 8'h0F;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/decimal_entry_button_debounce.sv
// Raw button conditioning: 2-flop synchroniser, optional counter debounce
// (DECIMAL_ENTRY_DEBOUNCE_EN) and a one-cycle press pulse on the rising edge.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press_c
);

    logic [1:0] sync_q;
    logic       level;
    logic       level_prev_q;

    if (DEBOUNCE_CYCLES == 0) begin : g_cfg_check
        $error("button_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

`ifdef DECIMAL_ENTRY_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    // Level follows the synchronised input only after DEBOUNCE_CYCLES unbroken disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync_q[1] == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            level_q <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level = level_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= 1'b0;
        end else begin
            level_prev_q <= level;
        end
    end

    assign press_c = level & ~level_prev_q;

endmodule

// File: rtl/decimal_entry.sv
// Decimal keypad entry: accumulates up to MAX_DIGITS decimal digits and commits
// the value as a one-cycle register-file write. Debounce via DECIMAL_ENTRY_DEBOUNCE_EN.
module decimal_entry
    import decimal_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TARGET_REG      = 26,
    parameter int unsigned MAX_DIGITS      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       btn_digit,
    input  logic                       btn_commit,
    input  logic                       btn_clear,
    input  logic [DIGIT_W-1:0]         sw_digit,
    output logic                       enable_write,
    output reg_id_t                    write_id,
    output op_t                        write_data,
    output digit_t [PREVIEW_DIGITS-1:0] preview,
    output logic [PREVIEW_EN_W-1:0]    preview_en,
    output logic                       digit_err
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    if (TARGET_REG < 1 || TARGET_REG > 31) begin : g_target_check
        $error("decimal_entry: TARGET_REG must be 1..31");
    end
    if (MAX_DIGITS < 1 || MAX_DIGITS > PREVIEW_DIGITS) begin : g_digits_check
        $error("decimal_entry: MAX_DIGITS must be 1..4");
    end

    logic digit_press_c, commit_press_c, clear_press_c;
    digit_t sw_meta_q, sw_q;

    entry_state_t                state_q, state_d;
    acc_t                        value_q, value_d;
    logic [CNT_W-1:0]            count_q, count_d;
    digit_t [PREVIEW_DIGITS-1:0] preview_d;
    logic                        digit_err_d;
    logic                        enable_write_d;
    reg_id_t                     write_id_d;
    op_t                         write_data_d;
    logic [PREVIEW_EN_W-1:0]     preview_en_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_digit (
        .clk(clk), .rst_n(rst_n), .raw(btn_digit), .press_c(digit_press_c)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_commit (
        .clk(clk), .rst_n(rst_n), .raw(btn_commit), .press_c(commit_press_c)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
        .clk(clk), .rst_n(rst_n), .raw(btn_clear), .press_c(clear_press_c)
    );

    // Digit switches: bare 2-flop synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= '0;
            sw_q      <= '0;
        end else begin
            sw_meta_q <= sw_digit;
            sw_q      <= sw_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            value_q      <= '0;
            count_q      <= '0;
            preview      <= '0;
            digit_err    <= 1'b0;
            enable_write <= 1'b0;
            write_id     <= '0;
            write_data   <= '0;
            preview_en   <= 8'h01;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            count_q      <= count_d;
            preview      <= preview_d;
            digit_err    <= digit_err_d;
            enable_write <= enable_write_d;
            write_id     <= write_id_d;
            write_data   <= write_data_d;
            preview_en   <= preview_en_d;
        end
    end

    // Next state; the BCD preview is shifted alongside the binary accumulator
    always_comb begin
        state_d        = state_q;
        value_d        = value_q;
        count_d        = count_q;
        preview_d      = preview;
        digit_err_d    = digit_err;
        enable_write_d = 1'b0;
        write_id_d     = '0;
        write_data_d   = '0;

        case (state_q)
            ST_WRITE: begin
                state_d     = ST_IDLE;
                value_d     = '0;
                count_d     = '0;
                preview_d   = '0;
                digit_err_d = 1'b0;
            end
            default: begin
                if (clear_press_c) begin
                    state_d     = ST_IDLE;
                    value_d     = '0;
                    count_d     = '0;
                    preview_d   = '0;
                    digit_err_d = 1'b0;
                end else if (commit_press_c) begin
                    state_d        = ST_WRITE;
                    enable_write_d = 1'b1;
                    write_id_d     = REG_ID_W'(TARGET_REG);
                    write_data_d   = OP_W'(value_q);
                end else if (digit_press_c) begin
                    if (sw_q > 4'd9 || count_q == CNT_MAX) begin
                        digit_err_d = 1'b1;
                    end else if (!(count_q == '0 && sw_q == 4'd0)) begin
                        state_d   = ST_ENTRY;
                        value_d   = times10_plus(value_q, sw_q);
                        count_d   = count_q + 1'b1;
                        preview_d = {preview[PREVIEW_DIGITS-2:0], sw_q};
                    end
                end
            end
        endcase

        preview_en_d = enable_mask(32'(count_d));
    end

endmodule

// File: tb/tb_decimal_entry.sv
// Directed self-checking bench for decimal_entry: a plain-arithmetic model of
// value/count/error/write, compared against the DUT every cycle.
module tb_decimal_entry;

    localparam int D       = 8;
`ifdef DECIMAL_ENTRY_DEBOUNCE_EN
    localparam int LAT     = 3 + D;
`else
    localparam int LAT     = 3;
`endif
    localparam int RELW    = LAT + 2;
    localparam int TGT     = 26;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_digit = 1'b0, btn_commit = 1'b0, btn_clear = 1'b0;
    logic [3:0]  sw_digit = 4'd0;
    logic        enable_write;
    logic [4:0]  write_id;
    logic [31:0] write_data;
    logic [3:0][3:0] preview;
    logic [7:0]  preview_en;
    logic        digit_err;

    decimal_entry #(.DEBOUNCE_CYCLES(D), .TARGET_REG(TGT), .MAX_DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_digit(btn_digit), .btn_commit(btn_commit), .btn_clear(btn_clear),
        .sw_digit(sw_digit),
        .enable_write(enable_write), .write_id(write_id), .write_data(write_data),
        .preview(preview), .preview_en(preview_en), .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;
    int n_strobe = 0, last_wdata = -1, last_wid = -1;
    bit chk_en = 1'b0;

    // Model state
    int m_val = 0, m_cnt = 0, m_err = 0, m_we = 0, m_wdata = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    function automatic int exp_preview(input int v);
        int r = 0, p = 1;
        for (int i = 0; i < 4; i++) begin
            r = r | (((v / p) % 10) << (4 * i));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int exp_en(input int c);
        return (c <= 1) ? 1 : ((1 << c) - 1);
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("enable_write", int'(enable_write), m_we);
            chk("write_id", int'(write_id), m_we != 0 ? TGT : 0);
            chk("write_data", int'(write_data), m_we != 0 ? m_wdata : 0);
            chk("preview", int'(preview), exp_preview(m_val));
            chk("preview_en", int'(preview_en), exp_en(m_cnt));
            chk("digit_err", int'(digit_err), m_err);
            if (enable_write) begin
                n_strobe++;
                last_wdata = int'(write_data);
                last_wid   = int'(write_id);
            end
        end
    end

    task automatic model_zero();
        m_val = 0; m_cnt = 0; m_err = 0; m_we = 0; m_wdata = 0;
    endtask

    // Drive raw buttons just after an edge, apply the model when the DUT updates,
    // then release and let the buttons settle low.
    task automatic press(input bit dg, input bit cm, input bit cl, input int sw, input bit rst_in_write = 1'b0);
        @(posedge clk); #1;
        btn_digit = dg; btn_commit = cm; btn_clear = cl; sw_digit = 4'(sw);
        repeat (LAT) @(posedge clk);
        #1;
        if (cl) begin
            model_zero();
        end else if (cm) begin
            m_we = 1; m_wdata = m_val;
        end else if (dg) begin
            if (sw > 9 || m_cnt == 4) m_err = 1;
            else if (!(m_cnt == 0 && sw == 0)) begin
                m_val = m_val * 10 + sw;
                m_cnt++;
            end
        end
        if (m_we != 0) begin
            if (rst_in_write) begin
                #2;
                chk_en = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("reset_drops_strobe", int'(enable_write), 0);
                chk("reset_drops_wdata", int'(write_data), 0);
                btn_digit = 1'b0; btn_commit = 1'b0; btn_clear = 1'b0;
                model_zero();
                @(posedge clk); #3;
                rst_n = 1'b1;
                chk_en = 1'b1;
            end else begin
                @(posedge clk); #1;
                model_zero();
            end
        end
        btn_digit = 1'b0; btn_commit = 1'b0; btn_clear = 1'b0;
        repeat (RELW) @(posedge clk);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        #1;
        chk("reset_preview_en", int'(preview_en), 8'h01);
        chk("reset_enable_write", int'(enable_write), 0);
        #19 rst_n = 1'b1;

        // 1,2,3 then commit
        press(1, 0, 0, 1); chk("lit_en_1", int'(preview_en), 8'h01);
        press(1, 0, 0, 2); chk("lit_en_12", int'(preview_en), 8'h03);
        press(1, 0, 0, 3); chk("lit_en_123", int'(preview_en), 8'h07);
        chk("lit_prev_123", int'(preview), 16'h0123);
        press(0, 1, 0, 0);
        chk("lit_strobes_a", n_strobe, 1);
        chk("lit_wdata_123", last_wdata, 123);
        chk("lit_wid_26", last_wid, 26);
        chk("lit_prev_after_commit", int'(preview), 0);

        // Leading zeros, then commit from IDLE
        press(1, 0, 0, 0); press(1, 0, 0, 0); press(1, 0, 0, 7);
        chk("lit_en_007", int'(preview_en), 8'h01);
        press(0, 1, 0, 0);
        chk("lit_wdata_7", last_wdata, 7);
        press(0, 1, 0, 0);
        chk("lit_strobes_b", n_strobe, 3);
        chk("lit_wdata_idle", last_wdata, 0);

        // Overflow of digit count
        for (int i = 0; i < 4; i++) press(1, 0, 0, 9);
        press(1, 0, 0, 5);
        chk("lit_prev_9999", int'(preview), 16'h9999);
        chk("lit_err_full", int'(digit_err), 1);
        press(0, 1, 0, 0);
        chk("lit_wdata_9999", last_wdata, 9999);
        chk("lit_err_cleared", int'(digit_err), 0);

        // Non-decimal digit, then clear
        press(1, 0, 0, 4);
        press(1, 0, 0, 12);
        chk("lit_err_hex", int'(digit_err), 1);
        chk("lit_prev_4", int'(preview), 16'h0004);
        press(0, 0, 1, 0);
        chk("lit_prev_clear", int'(preview), 0);
        chk("lit_err_clear", int'(digit_err), 0);
        chk("lit_strobes_c", n_strobe, 4);

        // Same-cycle priorities
        press(1, 0, 0, 5);
        press(0, 1, 1, 0);
        chk("lit_strobes_clr_cm", n_strobe, 4);
        chk("lit_prev_clr_cm", int'(preview), 0);
        press(1, 0, 0, 6);
        press(1, 1, 0, 3);
        chk("lit_strobes_cm_dg", n_strobe, 5);
        chk("lit_wdata_6", last_wdata, 6);

        // Reset during the write cycle
        press(1, 0, 0, 4); press(1, 0, 0, 2);
        press(0, 1, 0, 0, 1'b1);
        repeat (5) @(posedge clk);
        chk("lit_strobes_rst", n_strobe, 5);

`ifdef DECIMAL_ENTRY_DEBOUNCE_EN
        // A 5-cycle glitch must not register as a press
        press(1, 0, 0, 8);
        @(posedge clk); #1 btn_digit = 1'b1;
        repeat (5) @(posedge clk);
        #1 btn_digit = 1'b0;
        repeat (3 * D) @(posedge clk);
        chk("lit_glitch_prev", int'(preview), 16'h0008);
        press(0, 1, 0, 0);
        chk("lit_wdata_8", last_wdata, 8);
`endif

        @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/decimal_entry.md
# decimal_entry

Decimal keypad entry unit: the input-side counterpart of the register-file seven-segment readout. It debounces three push-buttons and a 4-bit digit switch bank, accumulates up to four decimal digits into a binary value, and on commit drives a single-cycle write into the register-file write port (`enable_write`/`write_id`/`write_data`). It also exports a live BCD preview of the digits being entered for the display path.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles before a debounced level changes.
- `TARGET_REG`, 26: register index written on commit; must be 1..31.
- `MAX_DIGITS`, 4: maximum accepted digits (value range 0..9999).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `btn_digit`  in  1  raw button, enter `sw_digit`.
- `btn_commit`  in  1  raw button, write value to `TARGET_REG`.
- `btn_clear`  in  1  raw button, discard entry.
- `sw_digit`  in  4  raw digit switches; sampled through the same synchroniser.
- `enable_write`  out  1  one-cycle write strobe to the register file.
- `write_id`  out  5  always `TARGET_REG` while `enable_write`=1, else 0.
- `write_data`  out  32  zero-extended accumulated value while `enable_write`=1, else 0.
- `preview`  out  4x4  BCD digits of the current value, [0] = least significant.
- `preview_en`  out  8  display enable mask: 0x01/0x03/0x07/0x0F by digit count (0x01 when count is 0).
- `digit_err`  out  1  sticky; set on rejected digit press, cleared by clear/commit.

## Operation
- Each button and `sw_digit` passes through a 2-flop synchroniser. Buttons are then debounced, and a rising edge of the debounced level produces a one-cycle press pulse.
- The FSM has three states:
  - IDLE: count=0, value=0.
  - ENTRY: 1 ≤ count ≤ MAX_DIGITS.
  - WRITE: exactly one cycle.
- Digit press, digit ≤ 9, count < MAX_DIGITS: value ← value*10 + digit (shift-add, 14-bit accumulator), count++.
  - Exception: a 0 pressed in IDLE keeps count and value at 0. Leading zeros are not counted.
- Digit press with digit > 9, or with count = MAX_DIGITS: value and count unchanged, `digit_err` ← 1.
- Commit press in IDLE or ENTRY: go to WRITE. In WRITE, `enable_write`=1 with `write_data`=value. Next cycle: IDLE, value=0, count=0, `digit_err`=0.
- Commit in IDLE writes 0.
- Clear press: IDLE, value=0, count=0, `digit_err`=0, no write.
- Priority for pulses in the same cycle: clear > commit > digit. Lower-priority pulses are dropped.
- All press pulses arriving while in WRITE are dropped.
- `preview` is computed from the registered value and count, never from `write_data`.

## Timing
- Reset values: every output is 0 except `preview_en`=0x01; state=IDLE; debounced levels=0.
- Raw button stable high from edge N:
  - with `DEBOUNCE_EN`: debounced level rises at N+2+DEBOUNCE_CYCLES, press pulse in that same cycle, value updated one edge later.
  - without `DEBOUNCE_EN`: press pulse at N+2.
- Commit pulse in cycle C: `enable_write` is high in cycle C+1 only. The register file latches the write at the end of C+1.
- Reset asserted mid-WRITE: the strobe drops immediately (asynchronous) and no write occurs after release.
- A held button produces a single press. A new press requires release (debounced low) first.

## Configuration
- `DECIMAL_ENTRY_DEBOUNCE_EN`:
  - Defined: per-button counter debounce as above.
  - Undefined: synchroniser and edge detect only. `DEBOUNCE_CYCLES` is ignored and no counters are synthesised. This build is used for simulation and for pre-debounced board inputs.

## Structure
- The shared types package holds:
  - `reg_id_t` and `op_t`, reused for `write_id`/`write_data`;
  - `digit_t` (4-bit BCD), reused for `preview`;
  - the FSM state enum `entry_state_t`.
- One sub-module, `button_debounce`: synchroniser, optional counter debounce and rising-edge pulse. It is instantiated three times. `sw_digit` uses a bare 2-flop sync.

## Test plan
- Press 1,2,3 then commit → one strobe, `write_id`=26, `write_data`=123. Preview during entry: 1 / 12 / 123; `preview_en` 0x01/0x03/0x07.
- Press 0,0,7, commit → `write_data`=7 and count stays 1 (`preview_en`=0x01). Commit from IDLE → `write_data`=0.
- Enter 9,9,9,9 then 5 → value stays 9999, `digit_err`=1. Commit → 9999 written, `digit_err` cleared.
- `sw_digit`=0xC with a digit press → value unchanged, `digit_err`=1. Clear → value 0, no strobe.
- Same-cycle clear+commit → no write, value 0. Same-cycle commit+digit → commit of the prior value only.
- With debounce and `DEBOUNCE_CYCLES`=8:
  - a 5-cycle glitch → no press;
  - a stable hold → exactly one press at edge N+10;
  - `rst_n` low during WRITE → `enable_write` falls at once.
